// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 8-bit MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing over one shared memory port. Optional retired-instruction counter: MC_CTRL_RETIRE_CNT_EN.
module mc_control_fsm #(
   parameter int OPCODE_W     = 3,
   parameter bit ILLEGAL_TRAP = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic                i_mem_ready,
   output logic                o_alu_src,
   output logic                o_mem_to_reg,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic                o_iord,
   output logic                o_ir_write,
   output logic                o_pc_write,
   output logic                o_jump,
   output logic                o_branch,
   output logic                o_reg_write,
   output logic                o_halted,
   output logic [3:0]          o_state,
   output logic [CNT_W-1:0]    o_retired
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_ADDR   = 4'd3,
      S_MEM_RD = 4'd4,
      S_MEM_WR = 4'd5,
      S_WB_MEM = 4'd6,
      S_EXEC_R = 4'd7,
      S_EXEC_I = 4'd8,
      S_WB_ALU = 4'd9,
      S_JUMP   = 4'd10,
      S_BRANCH = 4'd11,
      S_TRAP   = 4'd15
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5);

   state_t r_state;
   state_t w_next_state;
   logic   r_is_sw;
   logic   r_in_fetch;
   logic   r_alu_src;
   logic   r_mem_to_reg;
   logic   r_mem_read;
   logic   r_mem_write;
   logic   r_iord;
   logic   r_jump;
   logic   r_branch;
   logic   r_reg_write;
   logic   r_halted;

   // Next-state selection; opcode only matters in DECODE, mem_ready only in the memory-wait states
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH:  begin
            if (i_mem_ready) w_next_state = S_DECODE;
            else             w_next_state = S_FETCH;
         end
         S_DECODE: begin
            case (i_opcode)
               OP_LW, OP_SW: w_next_state = S_ADDR;
               OP_J:         w_next_state = S_JUMP;
               OP_R:         w_next_state = S_EXEC_R;
               OP_ADDI:      w_next_state = S_EXEC_I;
               OP_BEQ:       w_next_state = S_BRANCH;
               default: begin
                  if (ILLEGAL_TRAP) w_next_state = S_TRAP;
                  else              w_next_state = S_FETCH;
               end
            endcase
         end
         S_ADDR: begin
            if (r_is_sw) w_next_state = S_MEM_WR;
            else         w_next_state = S_MEM_RD;
         end
         S_MEM_RD: begin
            if (i_mem_ready) w_next_state = S_WB_MEM;
            else             w_next_state = S_MEM_RD;
         end
         S_MEM_WR: begin
            if (i_mem_ready) w_next_state = S_FETCH;
            else             w_next_state = S_MEM_WR;
         end
         S_WB_MEM: w_next_state = S_FETCH;
         S_EXEC_R: w_next_state = S_WB_ALU;
         S_EXEC_I: w_next_state = S_WB_ALU;
         S_WB_ALU: w_next_state = S_FETCH;
         S_JUMP:   w_next_state = S_FETCH;
         S_BRANCH: w_next_state = S_FETCH;
         S_TRAP:   w_next_state = S_TRAP;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // State register plus Moore outputs registered from the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_is_sw      <= 1'b0;
         r_in_fetch   <= 1'b0;
         r_alu_src    <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_iord       <= 1'b0;
         r_jump       <= 1'b0;
         r_branch     <= 1'b0;
         r_reg_write  <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) r_is_sw <= (i_opcode == OP_SW);
         else                     r_is_sw <= r_is_sw;
         // WB_ALU keeps whatever ALU B source the preceding EXEC state selected
         if (w_next_state == S_WB_ALU) r_alu_src <= r_alu_src;
         else r_alu_src <= (w_next_state == S_ADDR)   || (w_next_state == S_MEM_RD) ||
                           (w_next_state == S_MEM_WR) || (w_next_state == S_EXEC_I);
         r_in_fetch   <= (w_next_state == S_FETCH);
         r_mem_to_reg <= (w_next_state == S_WB_MEM);
         r_mem_read   <= (w_next_state == S_FETCH) || (w_next_state == S_MEM_RD);
         r_mem_write  <= (w_next_state == S_MEM_WR);
         r_iord       <= (w_next_state == S_MEM_RD) || (w_next_state == S_MEM_WR);
         r_jump       <= (w_next_state == S_JUMP);
         r_branch     <= (w_next_state == S_BRANCH);
         r_reg_write  <= (w_next_state == S_WB_MEM) || (w_next_state == S_WB_ALU);
         r_halted     <= (w_next_state == S_TRAP);
      end
   end

   assign o_state      = r_state;
   assign o_alu_src    = r_alu_src;
   assign o_mem_to_reg = r_mem_to_reg;
   assign o_mem_read   = r_mem_read;
   assign o_mem_write  = r_mem_write;
   assign o_iord       = r_iord;
   assign o_jump       = r_jump;
   assign o_branch     = r_branch;
   assign o_reg_write  = r_reg_write;
   assign o_halted     = r_halted;
   // Fetch exit pulses fire in the same cycle memory delivers the instruction
   assign o_ir_write   = r_in_fetch & i_mem_ready;
   assign o_pc_write   = r_in_fetch & i_mem_ready;

`ifdef MC_CTRL_RETIRE_CNT_EN
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;

   // Any return to FETCH other than from IDLE or a FETCH wait completes an instruction
   assign w_retire = (w_next_state == S_FETCH) && (r_state != S_FETCH) && (r_state != S_IDLE);

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_retired <= {CNT_W{1'b0}};
      else if (w_retire) r_retired <= r_retired + CNT_W'(1);
      else               r_retired <= r_retired;
   end

   assign o_retired = r_retired;
`else
   assign o_retired = {CNT_W{1'b0}};
`endif

endmodule
